// File: rtl/plab1_imul_zero_run_expander_pkg.sv
// plab1_imul_zero_run_expander_pkg: shared imul constants and state encodings for the zero-run expander
package plab1_imul_zero_run_expander_pkg;
  localparam int NBITS_DEF = 8;
  localparam int CW_DEF = 4;
  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;
endpackage

// File: rtl/plab1_imul_zero_run_expander_if.sv
// plab1_imul_zero_run_expander_if: val/rdy/msg stream channel
//   val/msg: producer to consumer, rdy: consumer to producer
//   master = producer view, slave = consumer view
interface plab1_imul_zero_run_expander_if #(
  parameter int W = 8
);
  logic         val;
  logic         rdy;
  logic [W-1:0] msg;
  modport master(output val, output msg, input rdy);
  modport slave(input val, input msg, output rdy);
endinterface

// File: rtl/plab1_imul_bit_decoder.sv
// plab1_imul_bit_decoder: maps a bit position to a one-hot fill mask plus a word-complete flag
//   t_i    : target position (one bit wider than a code, so it never wraps)
//   mask_o : one-hot bit t_i, all zero when t_i is past the word
//   done_o : the word is complete once this position is consumed
module plab1_imul_bit_decoder
  import plab1_imul_zero_run_expander_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic [CW:0]      t_i,
  output logic [NBITS-1:0] mask_o,
  output logic             done_o
);
  assign mask_o = (t_i < (CW+1)'(NBITS)) ? (NBITS'(1) << t_i) : '0;
  // Filling the MSB and overrunning the word both close it.
  assign done_o = t_i >= (CW+1)'(NBITS - 1);
endmodule

// File: rtl/plab1_imul_zero_run_expander.sv
// plab1_imul_zero_run_expander: rebuilds an operand word from a stream of trailing-zero skip codes
//   clk    : clock
//   reset  : asynchronous active-low reset
//   domain : security domain label, static while active
//   in_if  : skip code stream (code c = c zeros then a one)
//   out_if : reconstructed NBITS-wide word stream
module plab1_imul_zero_run_expander
  import plab1_imul_zero_run_expander_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int CW    = CW_DEF
) (
  input logic                           clk,
  input logic                           reset,
  input logic                           domain,
  plab1_imul_zero_run_expander_if.slave  in_if,
  plab1_imul_zero_run_expander_if.master out_if
);
  state_e           state_q, state_d;
  logic [CW-1:0]    pos_q, pos_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [CW-1:0]    c_sat;
  logic [CW:0]      t, t_inc;
  logic [NBITS-1:0] mask;
  logic             done;
  logic             unused_domain;
  assign unused_domain = domain;
  // Oversized codes behave exactly like a full-width skip.
  assign c_sat = (in_if.msg > CW'(NBITS)) ? CW'(NBITS) : in_if.msg;
  assign t     = {1'b0, pos_q} + {1'b0, c_sat};
  assign t_inc = t + (CW+1)'(1);
  plab1_imul_bit_decoder #(.NBITS(NBITS), .CW(CW)) u_dec (
    .t_i   (t),
    .mask_o(mask),
    .done_o(done)
  );
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    acc_d   = acc_q;
    if (state_q == ACC && in_if.val) begin
      acc_d   = acc_q | mask;
      // An empty mask marks a terminator: the position is held.
      pos_d   = |mask ? t_inc[CW-1:0] : pos_q;
      state_d = done ? OUT : ACC;
    end else if (state_q == OUT && out_if.rdy) begin
      acc_d   = '0;
      pos_d   = '0;
      state_d = ACC;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACC;
      pos_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      acc_q   <= acc_d;
    end
  end
  assign in_if.rdy  = state_q == ACC;
  assign out_if.val = state_q == OUT;
  assign out_if.msg = acc_q;
endmodule

// File: tb/tb_plab1_imul_zero_run_expander.sv
// tb_plab1_imul_zero_run_expander: directed and randomized checks of the zero-run expander
module tb_plab1_imul_zero_run_expander;
  logic clk = 1'b0;
  logic reset;
  logic domain;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   send_done;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  plab1_imul_zero_run_expander_if #(.W(4)) in_ch ();
  plab1_imul_zero_run_expander_if #(.W(8)) out_ch ();

  plab1_imul_zero_run_expander #(.NBITS(8), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .domain(domain),
    .in_if (in_ch),
    .out_if(out_ch)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && out_ch.val && out_ch.rdy) got_q.push_back(out_ch.msg);

  task automatic send(input logic [3:0] c);
    int n = 0;
    in_ch.val = 1'b1;
    in_ch.msg = c;
    while (!in_ch.rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_rdy=%b, required 1 within 100 cycles", in_ch.rdy);
    end
    @(posedge clk); #1;
    in_ch.val = 1'b0;
  endtask

  task automatic expect_word(input logic [7:0] exp, input string name);
    int n = 0;
    logic [7:0] g;
    while (got_q.size() == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (got_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no word within 100 cycles, required %02h", name, exp);
    end else begin
      g = got_q.pop_front();
      if (g !== exp) begin
        n_fail++;
        $display("FAIL %s: out_msg=%02h, required %02h", name, g, exp);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    domain = 1'b0;
    in_ch.val = 1'b0;
    in_ch.msg = '0;
    out_ch.rdy = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ch.rdy, out_ch.val, out_ch.msg} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset: rdy/val/msg=%b/%b/%02h, required 1/0/00", in_ch.rdy, out_ch.val, out_ch.msg);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_back_to_back;
    in_ch.val = 1'b1;
    in_ch.msg = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (in_ch.rdy !== 1'b1 || out_ch.val !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_accept%0d: in_rdy=%b out_val=%b, required 1/0", i, in_ch.rdy, out_ch.val);
      end
      @(posedge clk); #1;
    end
    in_ch.val = 1'b0;
    n_checks++;
    if (out_ch.val !== 1'b1 || out_ch.msg !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_out: out_val=%b out_msg=%02h, required 1/ff", out_ch.val, out_ch.msg);
    end
    expect_word(8'hFF, "b2b_word");
  endtask

  task automatic test_terminator;
    send(4'd1);
    send(4'd2);
    n_checks++;
    if (in_ch.rdy !== 1'b1 || out_ch.val !== 1'b0) begin
      n_fail++;
      $display("FAIL term_partial: in_rdy=%b out_val=%b, required 1/0", in_ch.rdy, out_ch.val);
    end
    send(4'd8);
    expect_word(8'h12, "term_word");
  endtask

  task automatic test_no_terminator;
    send(4'd3);
    send(4'd3);
    n_checks++;
    if (out_ch.val !== 1'b1 || in_ch.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL noterm_done: out_val=%b in_rdy=%b, required 1/0", out_ch.val, in_ch.rdy);
    end
    expect_word(8'h88, "noterm_word");
  endtask

  task automatic test_saturate;
    send(4'd15);
    expect_word(8'h00, "sat_word");
    send(4'd7);
    expect_word(8'h80, "msb_word");
    send(4'd0);
    send(4'd8);
    expect_word(8'h01, "after_msb_word");
  endtask

  task automatic test_stall;
    out_ch.rdy = 1'b0;
    send(4'd1);
    send(4'd2);
    send(4'd8);
    in_ch.val = 1'b1;
    in_ch.msg = 4'd7;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_ch.val, in_ch.rdy, out_ch.msg} !== {1'b1, 1'b0, 8'h12}) begin
        n_fail++;
        $display("FAIL stall%0d: val/rdy/msg=%b/%b/%02h, required 1/0/12", i, out_ch.val, in_ch.rdy, out_ch.msg);
      end
      @(posedge clk); #1;
    end
    out_ch.rdy = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ch.rdy !== 1'b1 || out_ch.val !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: in_rdy=%b out_val=%b, required 1/0", in_ch.rdy, out_ch.val);
    end
    @(posedge clk); #1;
    in_ch.val = 1'b0;
    expect_word(8'h12, "stall_word");
    expect_word(8'h80, "stall_next_word");
  endtask

  task automatic test_reset_mid_word;
    send(4'd0);
    send(4'd0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ch.rdy, out_ch.val, out_ch.msg} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL midreset: rdy/val/msg=%b/%b/%02h, required 1/0/00", in_ch.rdy, out_ch.val, out_ch.msg);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    send(4'd8);
    expect_word(8'h00, "midreset_word");
  endtask

  task automatic test_random;
    send_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 40; w++) begin
          logic [7:0] word;
          int pos;
          word = (w % 3 == 0) ? 8'($urandom & $urandom) : 8'($urandom);
          pos = 0;
          exp_q.push_back(word);
          for (int b = 0; b < 8; b++)
            if (word[b]) begin
              if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
              end
              send(4'(b - pos));
              pos = b + 1;
            end
          if (pos < 8) send(4'($urandom_range(15, 8 - pos)));
        end
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          out_ch.rdy = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ch.rdy = 1'b1;
      end
    join
    while (exp_q.size() > 0) expect_word(exp_q.pop_front(), "random_word");
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_extra: %0d extra words, required 0", got_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_terminator;
    test_no_terminator;
    test_saturate;
    test_stall;
    test_reset_mid_word;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
